asp_irq_ctrl: RTL and testbench

- Interrupt aggregation stage between the ASP interrupt sources (DMA_0, kernel, DMA_1) and the host-channel interrupt request port.
- Edge-detects the level sources and latches them as pending.
- Applies a host-programmable mask and arbitrates eligible lines round-robin.
- Issues one request/acknowledge transaction per pending line toward the FIM; CSRs are reached over a small MMIO slave.

---
 rtl/asp_irq_ctrl.sv | 157 +++++++++++++++
 tb/tb_asp_irq_ctrl.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/asp_irq_ctrl.sv
// Interrupt aggregation for the ASP sources: edge-detect, pending latch, host mask,
// round-robin arbitration and a single req/ack transaction per pending line.
module asp_irq_ctrl #(
   parameter int NUM_IRQ_LINES  = 4,
   parameter int NUM_IRQ_USED   = 3,
   parameter int CSR_DATA_WIDTH = 64,
   parameter int CSR_ADDR_WIDTH = 2,
   parameter int CNT_WIDTH      = 16,
   localparam int VEC_W = (NUM_IRQ_LINES > 1) ? $clog2(NUM_IRQ_LINES) : 1
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [NUM_IRQ_LINES-1:0]  irq_src,
   input  logic [CSR_ADDR_WIDTH-1:0] csr_address,
   input  logic                      csr_read,
   input  logic                      csr_write,
   input  logic [CSR_DATA_WIDTH-1:0] csr_writedata,
   output logic [CSR_DATA_WIDTH-1:0] csr_readdata,
   output logic                      csr_readdatavalid,
   output logic                      csr_waitrequest,
   output logic                      irq_req,
   output logic [VEC_W-1:0]          irq_vec,
   input  logic                      irq_ack
);

   localparam logic [NUM_IRQ_LINES-1:0] USED_MASK =
      {NUM_IRQ_LINES{1'b1}} >> (NUM_IRQ_LINES - NUM_IRQ_USED);

   localparam logic [CSR_ADDR_WIDTH-1:0] ADDR_STATUS = CSR_ADDR_WIDTH'(0);
   localparam logic [CSR_ADDR_WIDTH-1:0] ADDR_MASK   = CSR_ADDR_WIDTH'(1);
   localparam logic [CSR_ADDR_WIDTH-1:0] ADDR_CLEAR  = CSR_ADDR_WIDTH'(2);
   localparam logic [CSR_ADDR_WIDTH-1:0] ADDR_COUNT  = CSR_ADDR_WIDTH'(3);

   typedef enum logic [1:0] {IDLE, REQ, GAP} state_t;

   state_t                     state;
   state_t                     state_next;
   logic [NUM_IRQ_LINES-1:0]   prev_src;
   logic [NUM_IRQ_LINES-1:0]   pending;
   logic [NUM_IRQ_LINES-1:0]   mask;
   logic [NUM_IRQ_LINES-1:0]   rise;
   logic [NUM_IRQ_LINES-1:0]   eligible;
   logic [NUM_IRQ_LINES-1:0]   clr_bits;
   logic [VEC_W-1:0]           last_grant;
   logic [VEC_W-1:0]           grant;
   logic [CNT_WIDTH-1:0]       count;
   logic                       issue;
   logic                       accept;
   logic                       wr_mask;
   logic                       wr_clear;
   logic                       wr_count;
   logic [CSR_DATA_WIDTH-1:0]  rd_mux;
   logic                       unused_wdata;

   // First eligible line strictly after the previous grant, wrapping around.
   function automatic logic [VEC_W-1:0] rr_pick(input logic [NUM_IRQ_LINES-1:0] elig,
                                                input logic [VEC_W-1:0]         last);
      logic [VEC_W-1:0] pick;
      logic [VEC_W-1:0] sel;
      logic             found;
      int               idx;
      pick  = last;
      found = 1'b0;
      for (int k = 1; k <= NUM_IRQ_LINES; k++) begin
         idx = (int'(last) + k) % NUM_IRQ_LINES;
         sel = VEC_W'(idx);
         if (!found && elig[sel]) begin
            pick  = sel;
            found = 1'b1;
         end
      end
      return pick;
   endfunction

   assign rise         = irq_src & ~prev_src & USED_MASK;
   assign eligible     = pending & ~mask & USED_MASK;
   assign grant        = rr_pick(eligible, last_grant);
   assign wr_mask      = csr_write && (csr_address == ADDR_MASK);
   assign wr_clear     = csr_write && (csr_address == ADDR_CLEAR);
   assign wr_count     = csr_write && (csr_address == ADDR_COUNT);
   assign csr_waitrequest = 1'b0;
   assign unused_wdata = ^csr_writedata[CSR_DATA_WIDTH-1:NUM_IRQ_LINES];

   always_comb begin
      state_next = state;
      issue      = 1'b0;
      accept     = 1'b0;
      case (state)
         IDLE: if (|eligible) begin
            issue      = 1'b1;
            state_next = REQ;
         end
         REQ: if (irq_ack) begin
            accept     = 1'b1;
            state_next = GAP;
         end
         GAP:     state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // A fresh rise is OR-ed in after clearing, so set wins over ack/W1C clear.
   always_comb begin
      clr_bits = '0;
      if (wr_clear) clr_bits = csr_writedata[NUM_IRQ_LINES-1:0];
      if (accept)   clr_bits[irq_vec] = 1'b1;
   end

   always_comb begin
      rd_mux = '0;
      case (csr_address)
         ADDR_STATUS: begin
            rd_mux[NUM_IRQ_LINES-1:0]  = irq_src;
            rd_mux[8 +: NUM_IRQ_LINES] = pending;
            rd_mux[16]                 = (state != IDLE);
         end
         ADDR_MASK:  rd_mux[NUM_IRQ_LINES-1:0] = mask | ~USED_MASK;
         ADDR_COUNT: rd_mux[CNT_WIDTH-1:0]     = count;
         default:    rd_mux = '0;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_next;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         prev_src          <= '0;
         pending           <= '0;
         mask              <= '0;
         last_grant        <= VEC_W'(NUM_IRQ_LINES - 1);
         count             <= '0;
         irq_req           <= 1'b0;
         irq_vec           <= '0;
         csr_readdata      <= '0;
         csr_readdatavalid <= 1'b0;
      end else begin
         prev_src <= irq_src;
         pending  <= (pending & ~clr_bits) | rise;
         if (wr_mask) mask <= csr_writedata[NUM_IRQ_LINES-1:0] & USED_MASK;
         if (issue) begin
            irq_req <= 1'b1;
            irq_vec <= grant;
         end else if (accept) begin
            irq_req <= 1'b0;
         end
         if (accept) last_grant <= irq_vec;
         if (wr_count)    count <= '0;
         else if (accept) count <= count + CNT_WIDTH'(1);
         csr_readdatavalid <= csr_read;
         if (csr_read) csr_readdata <= rd_mux;
      end
   end

endmodule

// File: tb/tb_asp_irq_ctrl.sv
// Bench for asp_irq_ctrl: directed scenarios plus randomized traffic against a
// cycle-level behavioural model of the interrupt aggregation rules.
module tb_asp_irq_ctrl;
   localparam int N  = 4;
   localparam int DW = 64;
   localparam int AW = 2;
   localparam int CW = 8;
   localparam logic [N-1:0] USED_M = 4'b0111;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic [N-1:0]  irq_src = '0;
   logic [AW-1:0] csr_address = '0;
   logic          csr_read = 1'b0;
   logic          csr_write = 1'b0;
   logic [DW-1:0] csr_writedata = '0;
   logic [DW-1:0] csr_readdata;
   logic          csr_readdatavalid;
   logic          csr_waitrequest;
   logic          irq_req;
   logic [1:0]    irq_vec;
   logic          irq_ack = 1'b0;

   int checks = 0;
   int errors = 0;

   logic auto_ack = 1'b0;
   logic stray_en = 1'b0;
   logic man_ack  = 1'b0;
   int   ack_delay = 0;
   int   rcnt = 0;

   int   issued[$];
   int   issued_t[$];
   int   cyc_no = 0;
   logic req_d = 1'b0;

   // behavioural model state
   logic [N-1:0]  m_pend = '0;
   logic [N-1:0]  m_mask = '0;
   logic [N-1:0]  m_prev = '0;
   logic [1:0]    m_last = 2'd3;
   logic [1:0]    m_vec = '0;
   logic [CW-1:0] m_count = '0;
   logic          m_req = 1'b0;
   logic          m_gap = 1'b0;
   logic          m_rdv = 1'b0;
   logic [DW-1:0] m_rd = '0;

   asp_irq_ctrl #(.NUM_IRQ_LINES(N), .NUM_IRQ_USED(3), .CSR_DATA_WIDTH(DW),
                  .CSR_ADDR_WIDTH(AW), .CNT_WIDTH(CW)) dut (
      .clk(clk), .reset(reset), .irq_src(irq_src),
      .csr_address(csr_address), .csr_read(csr_read), .csr_write(csr_write),
      .csr_writedata(csr_writedata), .csr_readdata(csr_readdata),
      .csr_readdatavalid(csr_readdatavalid), .csr_waitrequest(csr_waitrequest),
      .irq_req(irq_req), .irq_vec(irq_vec), .irq_ack(irq_ack)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [DW-1:0] model_read(input logic [AW-1:0] a);
      logic [DW-1:0] r = '0;
      case (a)
         2'd0: begin
            r[N-1:0]  = irq_src;
            r[8 +: N] = m_pend;
            r[16]     = m_req | m_gap;
         end
         2'd1:    r[N-1:0]  = m_mask | ~USED_M;
         2'd3:    r[CW-1:0] = m_count;
         default: r = '0;
      endcase
      return r;
   endfunction

   // Model: one step per clock from the inputs seen at the edge.
   always @(posedge clk) begin : model
      logic [N-1:0]  rise;
      logic [N-1:0]  elig;
      logic [N-1:0]  clr;
      logic [CW-1:0] cnt_n;
      int            idx;
      if (reset) begin
         m_pend = '0; m_mask = '0; m_prev = '0; m_last = 2'(N - 1);
         m_vec = '0; m_count = '0; m_req = 1'b0; m_gap = 1'b0;
         m_rdv = 1'b0; m_rd = '0;
      end else begin
         rise  = irq_src & ~m_prev & USED_M;
         elig  = m_pend & ~m_mask & USED_M;
         clr   = '0;
         cnt_n = m_count;
         m_rdv = csr_read;
         if (csr_read) m_rd = model_read(csr_address);
         if (m_req) begin
            if (irq_ack) begin
               clr[m_vec] = 1'b1;
               m_last = m_vec;
               cnt_n  = m_count + CW'(1);
               m_req  = 1'b0;
               m_gap  = 1'b1;
            end
         end else if (m_gap) begin
            m_gap = 1'b0;
         end else if (elig != '0) begin
            for (int k = N; k >= 1; k--) begin
               idx = (int'(m_last) + k) % N;
               if (((elig >> idx) & 4'd1) != 4'd0) m_vec = 2'(idx);
            end
            m_req = 1'b1;
         end
         if (csr_write) begin
            case (csr_address)
               2'd1:    m_mask = csr_writedata[N-1:0] & USED_M;
               2'd2:    clr = clr | csr_writedata[N-1:0];
               2'd3:    cnt_n = '0;
               default: ;
            endcase
         end
         m_pend  = (m_pend & ~clr) | rise;
         m_count = cnt_n;
         m_prev  = irq_src;
      end
   end

   always @(negedge clk) begin
      if (reset) begin
         chk("req_in_reset", 64'(irq_req), 64'd0);
         chk("rdv_in_reset", 64'(csr_readdatavalid), 64'd0);
      end else begin
         chk("irq_req", 64'(irq_req), 64'(m_req));
         chk("irq_vec", 64'(irq_vec), 64'(m_vec));
         chk("readdatavalid", 64'(csr_readdatavalid), 64'(m_rdv));
         if (m_rdv) chk("readdata", csr_readdata, m_rd);
         chk("waitrequest", 64'(csr_waitrequest), 64'd0);
      end
      if (irq_req && !req_d) begin
         issued.push_back(int'(irq_vec));
         issued_t.push_back(cyc_no);
      end
      req_d = irq_req;
      cyc_no++;
   end

   // Host-channel responder.
   always begin
      @(posedge clk);
      #3;
      if (auto_ack) begin
         if (irq_req) begin
            rcnt++;
            irq_ack = (rcnt >= ack_delay + 1);
         end else begin
            rcnt = 0;
            irq_ack = stray_en ? 1'($urandom_range(0, 1)) : 1'b0;
         end
      end else begin
         rcnt = 0;
         irq_ack = man_ack;
      end
   end

   task automatic cyc(input int n);
      repeat (n) begin
         @(posedge clk);
         #2;
      end
   endtask

   task automatic do_reset();
      reset = 1'b1; irq_src = '0; csr_read = 1'b0; csr_write = 1'b0; man_ack = 1'b0;
      cyc(3);
      reset = 1'b0;
   endtask

   task automatic csr_wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
      csr_address = a; csr_writedata = d; csr_write = 1'b1;
      cyc(1);
      csr_write = 1'b0;
   endtask

   task automatic csr_rd(input logic [AW-1:0] a, output logic [DW-1:0] d);
      csr_address = a; csr_read = 1'b1;
      cyc(1);
      csr_read = 1'b0;
      d = csr_readdata;
   endtask

   task automatic wait_req(input int budget, input string name);
      int n = 0;
      while (!irq_req && n < budget) begin
         cyc(1);
         n++;
      end
      chk({name, "_req_seen"}, 64'(irq_req), 64'd1);
   endtask

   task automatic pulse0();
      irq_src = 4'b0001; cyc(1); irq_src = '0; cyc(4);
   endtask

   initial begin : watchdog
      #1000000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "bench timeout");
   end

   initial begin : stim
      logic [DW-1:0] d;
      logic [N-1:0]  flip;
      int            r;

      // single kernel pulse, ack two cycles after the request
      do_reset();
      csr_rd(2'd1, d); chk("reset_mask", d, 64'h8);
      csr_rd(2'd0, d); chk("reset_status", d, 64'h0);
      do_reset();
      irq_src = 4'b0010; cyc(1); irq_src = '0;
      chk("t1_no_req_cycle1", 64'(irq_req), 64'd0);
      cyc(1);
      chk("t1_req_cycle2", 64'(irq_req), 64'd1);
      chk("t1_vec", 64'(irq_vec), 64'd1);
      cyc(2); man_ack = 1'b1; cyc(1); man_ack = 1'b0;
      chk("t1_req_dropped", 64'(irq_req), 64'd0);
      cyc(2);
      csr_rd(2'd3, d); chk("t1_count", d, 64'd1);
      csr_rd(2'd0, d); chk("t1_pending", 64'(d[11:8]), 64'd0);

      // all three lines rise together, immediate acks
      do_reset(); auto_ack = 1'b1; ack_delay = 0; issued.delete(); issued_t.delete();
      irq_src = 4'b0111; cyc(1); irq_src = '0; cyc(14);
      chk("t2_num_issued", 64'(issued.size()), 64'd3);
      for (int i = 0; i < 3; i++)
         chk($sformatf("t2_vec%0d", i), 64'((i < issued.size()) ? issued[i] : -1), 64'(i));
      chk("t2_spacing", 64'((issued_t.size() >= 3) ? issued_t[2] - issued_t[1] : 0), 64'd3);
      csr_rd(2'd3, d); chk("t2_count", d, 64'd3);

      // masked line stays pending until unmasked
      do_reset(); issued.delete();
      csr_wr(2'd1, 64'h1);
      irq_src = 4'b0001; cyc(1); irq_src = '0; cyc(4);
      chk("t3_masked_no_req", 64'(issued.size()), 64'd0);
      csr_rd(2'd0, d); chk("t3_pending0", 64'(d[11:8]), 64'd1);
      csr_wr(2'd1, 64'h0);
      cyc(1);
      chk("t3_req_after_unmask", 64'(irq_req), 64'd1);
      chk("t3_vec", 64'(irq_vec), 64'd0);
      cyc(4);

      // rise on line 2 coincident with the ack of vec 2
      do_reset(); auto_ack = 1'b0; issued.delete();
      irq_src = 4'b0100; cyc(1); irq_src = '0;
      wait_req(4, "t4a"); chk("t4_vec_first", 64'(irq_vec), 64'd2);
      irq_src = 4'b0100; man_ack = 1'b1; cyc(1); irq_src = '0; man_ack = 1'b0;
      chk("t4_req_dropped", 64'(irq_req), 64'd0);
      csr_rd(2'd0, d); chk("t4_pending2_kept", 64'(d[10]), 64'd1);
      wait_req(4, "t4b"); chk("t4_vec_second", 64'(irq_vec), 64'd2);
      man_ack = 1'b1; cyc(1); man_ack = 1'b0; cyc(3);
      csr_rd(2'd3, d); chk("t4_count", d, 64'd2);

      // W1C of the in-flight line; unused line never pends
      do_reset(); auto_ack = 1'b0; issued.delete();
      irq_src = 4'b1001; cyc(1); irq_src = 4'b1000;
      wait_req(4, "t5"); chk("t5_vec", 64'(irq_vec), 64'd0);
      csr_wr(2'd2, 64'h1);
      cyc(2);
      chk("t5_req_held", 64'(irq_req), 64'd1);
      man_ack = 1'b1; cyc(1); man_ack = 1'b0;
      cyc(6);
      chk("t5_no_repeat", 64'(issued.size()), 64'd1);
      csr_rd(2'd0, d);
      chk("t5_pending_none", 64'(d[11:8]), 64'd0);
      chk("t5_src3_raw", 64'(d[3]), 64'd1);
      irq_src = '0;

      // COUNT clear-on-write and wrap
      do_reset(); auto_ack = 1'b1; ack_delay = 0;
      repeat (3) pulse0();
      csr_wr(2'd3, 64'h5A);
      csr_rd(2'd3, d); chk("t6_count_cleared", d, 64'd0);
      repeat (255) pulse0();
      csr_rd(2'd3, d); chk("t6_count_max", d, 64'hFF);
      pulse0();
      csr_rd(2'd3, d); chk("t6_count_wrap", d, 64'd0);

      // reset while a request is outstanding
      pulse0();
      csr_wr(2'd1, 64'h4); auto_ack = 1'b0;
      irq_src = 4'b0001; cyc(1); irq_src = '0;
      wait_req(4, "t7");
      reset = 1'b1;
      #1;
      chk("t7_req_drop_async", 64'(irq_req), 64'd0);
      cyc(2);
      reset = 1'b0;
      man_ack = 1'b1; cyc(1); man_ack = 1'b0;
      cyc(2);
      csr_rd(2'd0, d); chk("t7_status", d, 64'd0);
      csr_rd(2'd1, d); chk("t7_mask", d, 64'h8);
      csr_rd(2'd2, d); chk("t7_clear", d, 64'd0);
      csr_rd(2'd3, d); chk("t7_count", d, 64'd0);
      chk("t7_no_req_after_stray", 64'(irq_req), 64'd0);

      // randomized traffic
      do_reset(); auto_ack = 1'b1; stray_en = 1'b1;
      for (int i = 0; i < 3000; i++) begin
         flip = '0;
         for (int b = 0; b < N; b++)
            if ($urandom_range(0, 5) == 0) flip = flip | 4'(1 << b);
         irq_src   = irq_src ^ flip;
         csr_read  = 1'b0;
         csr_write = 1'b0;
         r = $urandom_range(0, 15);
         if (r < 4) begin
            csr_read = 1'b1;
            csr_address = 2'($urandom_range(0, 3));
         end else if (r < 7) begin
            csr_address   = 2'($urandom_range(1, 3));
            csr_writedata = {$urandom, $urandom};
            csr_write     = !(csr_address == 2'd3 && irq_req);
            csr_read      = (r == 6);
         end
         if (i % 100 == 0) ack_delay = $urandom_range(0, 3);
         cyc(1);
      end
      irq_src = '0; csr_read = 1'b0; csr_write = 1'b0; stray_en = 1'b0;
      cyc(8);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
